mpi_host_master: RTL

- Synthesizable host-side initiator for the 8-bit asynchronous microprocessor interface (MPI) bus: Mpi_addr[5:0], Mpi_cs_n, Mpi_rw, tri-state Mpi_data[7:0].
- Converts a valid/ready request (read or write, address, write data) into one timed bus access with a programmable cycle count per phase.
- Returns read data with a one-cycle response pulse.
- Sits between an on-chip controller and the MPI responder (register file / MPI slave).

---
 rtl/mpi_host_master.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mpi_host_master.sv
// Host-side initiator for the 8-bit asynchronous MPI bus: turns one valid/ready request into a
// timed SETUP/LEAD/STROBE/HOLD/TURN access and returns read data with a one-cycle response pulse.
module mpi_host_master #(
    parameter int unsigned SETUP_CYC  = 3,
    parameter int unsigned LEAD_CYC   = 1,
    parameter int unsigned STROBE_CYC = 6,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned TURN_CYC   = 3
) (
    input  logic       Clock,
    input  logic       Rst_n,
    input  logic       Req_valid,
    output logic       Req_ready,
    input  logic       Req_write,
    input  logic [5:0] Req_addr,
    input  logic [7:0] Req_wdata,
    output logic       Rsp_valid,
    output logic [7:0] Rsp_rdata,
    output logic [5:0] Mpi_addr,
    output logic       Mpi_cs_n,
    output logic       Mpi_rw,
    output logic       Mpi_oe,
    inout  wire  [7:0] Mpi_data
);

    // Counter load value is cycles-1; 0 behaves as 1 and anything above 15 saturates at 15.
    function automatic logic [3:0] load_val(input int unsigned cyc);
        if (cyc <= 1) begin
            return 4'd0;
        end else if (cyc >= 15) begin
            return 4'd14;
        end else begin
            return 4'(cyc - 1);
        end
    endfunction

    localparam logic [3:0] SetupLd  = load_val(SETUP_CYC);
    localparam logic [3:0] LeadLd   = load_val(LEAD_CYC);
    localparam logic [3:0] StrobeLd = load_val(STROBE_CYC);
    localparam logic [3:0] HoldLd   = load_val(HOLD_CYC);
    localparam logic [3:0] TurnLd   = load_val(TURN_CYC);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSetup  = 3'd1;
    localparam logic [2:0] StLead   = 3'd2;
    localparam logic [2:0] StStrobe = 3'd3;
    localparam logic [2:0] StHold   = 3'd4;
    localparam logic [2:0] StTurn   = 3'd5;

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       write_q, write_d;
    logic [5:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       ready_q, ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rdata_q, rdata_d;
    logic [5:0] mpi_addr_q, mpi_addr_d;
    logic       cs_n_q, cs_n_d;
    logic       rw_q, rw_d;
    logic       oe_q, oe_d;
    logic       cnt_zero;
    logic       in_access;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_zero = (cnt_q == 4'd0);

        if (state_q != StIdle && !cnt_zero) begin
            cnt_d = cnt_q - 4'd1;
        end

        case (state_q)
            StIdle: begin
                if (Req_valid && ready_q) begin
                    state_d = StSetup;
                    cnt_d   = SetupLd;
                    write_d = Req_write;
                    addr_d  = Req_addr;
                    wdata_d = Req_wdata;
                end
            end
            StSetup: begin
                if (cnt_zero) begin
                    state_d = StLead;
                    cnt_d   = LeadLd;
                end
            end
            StLead: begin
                if (cnt_zero) begin
                    state_d = StStrobe;
                    cnt_d   = StrobeLd;
                end
            end
            StStrobe: begin
                if (cnt_zero) begin
                    state_d = StHold;
                    cnt_d   = HoldLd;
                end
            end
            StHold: begin
                if (cnt_zero) begin
                    state_d = StTurn;
                    cnt_d   = TurnLd;
                end
            end
            StTurn: begin
                if (cnt_zero) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // The responder is still driving on the edge that ends the strobe.
        if (state_q == StStrobe && state_d == StHold && !write_q) begin
            rdata_d = Mpi_data;
        end

        in_access   = (state_d == StSetup) || (state_d == StLead) ||
                      (state_d == StStrobe) || (state_d == StHold);
        ready_d     = (state_d == StIdle);
        rsp_valid_d = (state_q == StHold) && (state_d == StTurn);
        mpi_addr_d  = in_access ? addr_d : 6'd0;
        rw_d        = in_access ? !write_d : 1'b1;
        cs_n_d      = (state_d != StStrobe);
        oe_d        = write_d &&
                      ((state_d == StLead) || (state_d == StStrobe) || (state_d == StHold));
    end

    always_ff @(posedge Clock) begin
        if (!Rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            addr_q      <= 6'd0;
            wdata_q     <= 8'd0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 8'd0;
            mpi_addr_q  <= 6'd0;
            cs_n_q      <= 1'b1;
            rw_q        <= 1'b1;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            mpi_addr_q  <= mpi_addr_d;
            cs_n_q      <= cs_n_d;
            rw_q        <= rw_d;
            oe_q        <= oe_d;
        end
    end

    assign Req_ready = ready_q;
    assign Rsp_valid = rsp_valid_q;
    assign Rsp_rdata = rdata_q;
    assign Mpi_addr  = mpi_addr_q;
    assign Mpi_cs_n  = cs_n_q;
    assign Mpi_rw    = rw_q;
    assign Mpi_oe    = oe_q;
    assign Mpi_data  = oe_q ? wdata_q : 8'hzz;

endmodule
